// File: rtl/pulse_stretch_multi_if.sv
// Control, trigger and status bundle for pulse_stretch_multi.
// master: period/holdoff/retrig/edge_mode/clr_cnt/in out; slave: out/any/evt_cnt out.
interface pulse_stretch_multi_if #(
   parameter int CHANNELS = 4,
   parameter int BITS     = 24,
   parameter int CNT_BITS = 8
);
   logic [BITS-1:0]              period;
   logic [BITS-1:0]              holdoff;
   logic                         retrig;
   logic                         edge_mode;
   logic                         clr_cnt;
   logic [CHANNELS-1:0]          in;
   logic [CHANNELS-1:0]          out;
   logic                         any;
   logic [CHANNELS*CNT_BITS-1:0] evt_cnt;

   modport master (
      output period, holdoff, retrig, edge_mode, clr_cnt, in,
      input  out, any, evt_cnt
   );

   modport slave (
      input  period, holdoff, retrig, edge_mode, clr_cnt, in,
      output out, any, evt_cnt
   );
endinterface

// File: rtl/pulse_stretch_multi.sv
// Multi-channel pulse stretcher with retrigger, holdoff, edge/level trigger
// and saturating event counters. Ports: clk, reset (sync, active high), bus (slave).
module pulse_stretch_multi #(
   parameter int CHANNELS = 4,
   parameter int BITS     = 24,
   parameter int CNT_BITS = 8
) (
   input logic                   clk,
   input logic                   reset,
   pulse_stretch_multi_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      STRETCH,
      HOLDOFF
   } state_e;

   localparam logic [BITS-1:0]     ONE     = BITS'(1);
   localparam logic [CNT_BITS-1:0] EVT_ONE = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] EVT_MAX = '1;

   state_e              state_q [CHANNELS];
   state_e              state_d [CHANNELS];
   logic [BITS-1:0]     cnt_q   [CHANNELS];
   logic [BITS-1:0]     cnt_d   [CHANNELS];
   logic [CNT_BITS-1:0] evt_q   [CHANNELS];
   logic [CNT_BITS-1:0] evt_d   [CHANNELS];
   logic [CHANNELS-1:0] out_q, out_d;
   logic [CHANNELS-1:0] in_d_q;
   logic [CHANNELS-1:0] trig;
   logic [CHANNELS-1:0] accept;
   logic                per_ok, hold_ok;

   // in_d_q follows the input in every state, so a held level fires once in edge mode
   always_comb begin
      trig    = bus.edge_mode ? (bus.in & ~in_d_q) : bus.in;
      per_ok  = (bus.period != '0);
      hold_ok = (bus.holdoff != '0);
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         out_d[i]   = out_q[i];
         accept[i]  = 1'b0;
         case (state_q[i])
            IDLE: begin
               out_d[i] = 1'b0;
               if (trig[i] && per_ok) begin
                  state_d[i] = STRETCH;
                  cnt_d[i]   = bus.period - ONE;
                  out_d[i]   = 1'b1;
                  accept[i]  = 1'b1;
               end
            end
            STRETCH: begin
               out_d[i] = 1'b1;
               // a disabled channel (period 0) cannot reload; it just runs out
               if (trig[i] && bus.retrig && per_ok) begin
                  cnt_d[i]  = bus.period - ONE;
                  accept[i] = 1'b1;
               end else if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - ONE;
               end else if (hold_ok) begin
                  state_d[i] = HOLDOFF;
                  cnt_d[i]   = bus.holdoff - ONE;
                  out_d[i]   = 1'b0;
               end else begin
                  state_d[i] = IDLE;
                  out_d[i]   = 1'b0;
               end
            end
            HOLDOFF: begin
               out_d[i] = 1'b0;
               if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - ONE;
               end else begin
                  state_d[i] = IDLE;
               end
            end
            default: begin
               state_d[i] = IDLE;
               out_d[i]   = 1'b0;
            end
         endcase
      end
   end

   // clear wins over a same-cycle increment; counters stick at all-ones
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         evt_d[i] = evt_q[i];
         if (bus.clr_cnt) begin
            evt_d[i] = '0;
         end else if (accept[i] && (evt_q[i] != EVT_MAX)) begin
            evt_d[i] = evt_q[i] + EVT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q  <= '0;
         in_d_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            evt_q[i]   <= '0;
         end
      end else begin
         out_q  <= out_d;
         in_d_q <= bus.in;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            evt_q[i]   <= evt_d[i];
         end
      end
   end

   assign bus.out = out_q;
   assign bus.any = |out_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_evt
      assign bus.evt_cnt[g*CNT_BITS +: CNT_BITS] = evt_q[g];
   end

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Directed testbench for pulse_stretch_multi: vector table for the
// single-channel timing cases, hand sequences for saturation, reset and multi-channel.
module tb_pulse_stretch_multi;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   pulse_stretch_multi_if #(
      .CHANNELS(4), .BITS(24), .CNT_BITS(8)
   ) bus ();

   pulse_stretch_multi #(
      .CHANNELS(4), .BITS(24), .CNT_BITS(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        em;
      logic        rt;
      logic [23:0] p;
      logic [23:0] h;
      logic [3:0]  i;
      logic [3:0]  eo;
      logic [7:0]  ec;
   } vec_t;

   vec_t        vecs[$];
   logic        c_em, c_rt;
   logic [23:0] c_p, c_h;

   task automatic add(input logic r, input logic [3:0] i,
                      input logic [3:0] eo, input logic [7:0] ec);
      vec_t v;
      v.rst = r;  v.em = c_em; v.rt = c_rt;
      v.p = c_p;  v.h = c_h;
      v.i = i;    v.eo = eo;   v.ec = ec;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [3:0] eo,
                          input logic [31:0] ec);
      chk({nm, " out"}, {28'h0, bus.out}, {28'h0, eo});
      chk({nm, " any"}, {31'h0, bus.any}, {31'h0, |eo});
      chk({nm, " evt"}, bus.evt_cnt, ec);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus.period = '0;
      bus.holdoff = '0;
      bus.retrig = 1'b0;
      bus.edge_mode = 1'b0;
      bus.clr_cnt = 1'b0;
      bus.in = '0;

      // 1: period 3, level, single pulse
      c_em = 0; c_rt = 0; c_p = 3; c_h = 0;
      add(1, 0, 0, 0);
      add(0, 1, 1, 1);
      add(0, 0, 1, 1);
      add(0, 0, 1, 1);
      add(0, 0, 0, 1);
      add(0, 0, 0, 1);
      // 2a: period 5, retrigger every 3 clocks
      c_rt = 1; c_p = 5;
      add(1, 0, 0, 0);
      add(0, 1, 1, 1);
      add(0, 0, 1, 1);
      add(0, 0, 1, 1);
      add(0, 1, 1, 2);
      add(0, 0, 1, 2);
      add(0, 0, 1, 2);
      add(0, 1, 1, 3);
      for (int k = 0; k < 4; k++) add(0, 0, 1, 3);
      add(0, 0, 0, 3);
      // 2b: one-shot, retrigger at +3 ignored, new pulse at +6
      c_rt = 0;
      add(1, 0, 0, 0);
      add(0, 1, 1, 1);
      add(0, 0, 1, 1);
      add(0, 0, 1, 1);
      add(0, 1, 1, 1);
      add(0, 0, 1, 1);
      add(0, 0, 0, 1);
      add(0, 1, 1, 2);
      for (int k = 0; k < 4; k++) add(0, 0, 1, 2);
      add(0, 0, 0, 2);
      // 3a: period 2, holdoff 4, held level: 4 holdoff + 1 idle low
      c_p = 2; c_h = 4;
      add(1, 0, 0, 0);
      add(0, 1, 1, 1);
      add(0, 1, 1, 1);
      for (int k = 0; k < 5; k++) add(0, 1, 0, 1);
      add(0, 1, 1, 2);
      add(0, 1, 1, 2);
      add(0, 1, 0, 2);
      // 3b: same in edge mode, one pulse only
      c_em = 1;
      add(1, 0, 0, 0);
      add(0, 1, 1, 1);
      add(0, 1, 1, 1);
      for (int k = 0; k < 8; k++) add(0, 1, 0, 1);

      foreach (vecs[k]) begin
         reset = vecs[k].rst;
         bus.edge_mode = vecs[k].em;
         bus.retrig = vecs[k].rt;
         bus.period = vecs[k].p;
         bus.holdoff = vecs[k].h;
         bus.in = vecs[k].i;
         step();
         chk_all($sformatf("vec%0d", k), vecs[k].eo, {24'h0, vecs[k].ec});
      end

      // 4: saturation and clear priority
      reset = 1'b1; bus.in = '0;
      step();
      chk_all("sat_rst", 4'h0, 32'h0);
      reset = 1'b0;
      bus.period = 1; bus.holdoff = 0;
      bus.retrig = 1'b1; bus.edge_mode = 1'b0;
      bus.in = 4'h1;
      repeat (255) step();
      chk_all("sat_255", 4'h1, 32'h0000_00ff);
      repeat (45) step();
      chk_all("sat_300", 4'h1, 32'h0000_00ff);
      bus.clr_cnt = 1'b1;
      step();
      chk("clr_vs_trig", bus.evt_cnt, 32'h0);
      bus.clr_cnt = 1'b0;
      step();
      chk("after_clr", bus.evt_cnt, 32'h1);

      // 5: disabled channel, then reset mid-pulse
      bus.in = '0; reset = 1'b1;
      step();
      reset = 1'b0;
      bus.period = 0; bus.retrig = 1'b0;
      bus.in = 4'hf;
      repeat (5) step();
      chk_all("per0", 4'h0, 32'h0);
      bus.in = '0;
      step();
      bus.period = 10;
      bus.in = 4'h1;
      step();
      chk_all("p10_hi1", 4'h1, 32'h1);
      bus.in = '0;
      repeat (3) step();
      chk_all("p10_hi4", 4'h1, 32'h1);
      reset = 1'b1;
      step();
      chk_all("mid_rst", 4'h0, 32'h0);
      reset = 1'b0;
      repeat (3) step();
      chk_all("post_rst", 4'h0, 32'h0);

      // 6: all channels together, period 7
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.period = 7; bus.holdoff = 0;
      bus.in = 4'hf;
      step();
      chk_all("all_c1", 4'hf, 32'h0101_0101);
      bus.in = '0;
      for (int k = 2; k <= 7; k++) begin
         step();
         chk_all($sformatf("all_c%0d", k), 4'hf, 32'h0101_0101);
      end
      step();
      chk_all("all_end", 4'h0, 32'h0101_0101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
